writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 101 ++++++++++
 tb/tb_writeback_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results into one register-file write port with a busy scoreboard
module writeback_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issueValid_i,
    input  logic [4:0]  issueRd_i,
    input  logic        aluValid_i,
    input  logic [4:0]  aluRd_i,
    input  logic [31:0] aluVal_i,
    output logic        aluReady_o,
    input  logic        memValid_i,
    input  logic [4:0]  memRd_i,
    input  logic [31:0] memVal_i,
    output logic        memReady_o,
    output logic [4:0]  rdNum_o,
    output logic [31:0] rdVal_o,
    output logic        regWrite_o,
    output logic [31:0] busy_o
);
    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]  in_valid, ready, push, pop, not_empty;
    logic [36:0] in_data [2];
    logic [36:0] head [2];
    logic [36:0] g_data;
    logic        grant, rr_mem;
    logic [31:0] set_mask, clr_mask;

    assign in_valid   = {memValid_i, aluValid_i};
    assign in_data[0] = {aluRd_i, aluVal_i};
    assign in_data[1] = {memRd_i, memVal_i};
    assign aluReady_o = ready[0];
    assign memReady_o = ready[1];

    // index 0 is the ALU queue, index 1 the load queue
    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [36:0]   store [FIFO_DEPTH];
        logic [PW-1:0] wp, rp;
        logic [CW-1:0] cnt;
        assign ready[s]     = cnt < CW'(FIFO_DEPTH);
        assign not_empty[s] = cnt != '0;
        assign push[s]      = in_valid[s] & ready[s];
        assign head[s]      = store[rp];
        // payload storage; occupancy gates every read so no reset is needed
        always_ff @(posedge clk) begin
            if (push[s]) store[wp] <= in_data[s];
        end
        // pointers wrap at the depth; the counter tells full from empty
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push[s]) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
                if (pop[s]) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
                cnt <= cnt + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    // one head per cycle; the round-robin pointer only decides when both queues hold data
    always_comb begin
        pop[1]   = not_empty[1] & (~not_empty[0] | rr_mem);
        pop[0]   = not_empty[0] & (~not_empty[1] | ~rr_mem);
        grant    = |pop;
        g_data   = pop[1] ? head[1] : head[0];
        set_mask = (issueValid_i && issueRd_i != 5'd0) ? 32'd1 << issueRd_i : 32'd0;
        clr_mask = (grant && g_data[36:32] != 5'd0) ? 32'd1 << g_data[36:32] : 32'd0;
    end

    // pointer flips only on contended cycles and favours the load side out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) rr_mem <= 1'b1;
        else if (&not_empty) rr_mem <= ~rr_mem;
    end

    // register-file write port; x0 results take a grant but never write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWrite_o <= 1'b0;
            rdNum_o    <= '0;
            rdVal_o    <= '0;
        end else begin
            regWrite_o <= grant && g_data[36:32] != 5'd0;
            if (grant) begin
                rdNum_o <= g_data[36:32];
                rdVal_o <= g_data[31:0];
            end
        end
    end

    // scoreboard: a new issue beats a same-edge retirement of that register
    always_ff @(posedge clk) begin
        if (!rst_n) busy_o <= '0;
        else busy_o <= ((busy_o & ~clr_mask) | set_mask) & ~32'd1;
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random stimulus against a queue-based reference model
module tb_writeback_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issueValid_i;
    logic [4:0]  issueRd_i;
    logic        aluValid_i;
    logic [4:0]  aluRd_i;
    logic [31:0] aluVal_i;
    logic        aluReady_o;
    logic        memValid_i;
    logic [4:0]  memRd_i;
    logic [31:0] memVal_i;
    logic        memReady_o;
    logic [4:0]  rdNum_o;
    logic [31:0] rdVal_o;
    logic        regWrite_o;
    logic [31:0] busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [36:0] aq[$];
    logic [36:0] mq[$];
    logic        m_rw, m_rr_mem;
    logic [4:0]  m_rdn;
    logic [31:0] m_rdv, m_busy;

    always #5 clk = ~clk;

    writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid_i(issueValid_i), .issueRd_i(issueRd_i),
        .aluValid_i(aluValid_i), .aluRd_i(aluRd_i), .aluVal_i(aluVal_i), .aluReady_o(aluReady_o),
        .memValid_i(memValid_i), .memRd_i(memRd_i), .memVal_i(memVal_i), .memReady_o(memReady_o),
        .rdNum_o(rdNum_o), .rdVal_o(rdVal_o), .regWrite_o(regWrite_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [36:0] g;
        bit gr, acc_a, acc_m;
        if (!rst_n) begin
            aq.delete();
            mq.delete();
            m_busy = 0; m_rw = 0; m_rdn = 0; m_rdv = 0; m_rr_mem = 1;
            return;
        end
        acc_a = aluValid_i && aq.size() < DEPTH;
        acc_m = memValid_i && mq.size() < DEPTH;
        gr = 1;
        g = '0;
        if (aq.size() > 0 && mq.size() > 0) begin
            g = m_rr_mem ? mq.pop_front() : aq.pop_front();
            m_rr_mem = !m_rr_mem;
        end else if (mq.size() > 0) g = mq.pop_front();
        else if (aq.size() > 0) g = aq.pop_front();
        else gr = 0;
        m_rw = gr && g[36:32] != 0;
        if (gr) begin
            m_rdn = g[36:32];
            m_rdv = g[31:0];
            if (g[36:32] != 0) m_busy[g[36:32]] = 1'b0;
        end
        if (acc_a) aq.push_back({aluRd_i, aluVal_i});
        if (acc_m) mq.push_back({memRd_i, memVal_i});
        if (issueValid_i && issueRd_i != 0) m_busy[issueRd_i] = 1'b1;
    endtask

    task automatic check_all();
        check("regWrite", regWrite_o, m_rw);
        check("rdNum", rdNum_o, m_rdn);
        check("rdVal", rdVal_o, m_rdv);
        check("busy", busy_o, m_busy);
        check("aluReady", aluReady_o, aq.size() < DEPTH);
        check("memReady", memReady_o, mq.size() < DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        issueValid_i = 0; issueRd_i = 0;
        aluValid_i = 0; aluRd_i = 0; aluVal_i = 0;
        memValid_i = 0; memRd_i = 0; memVal_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        int k;
        logic [31:0] vals [3];
        rst_n = 0;
        idle();
        @(negedge clk);
        tick();
        do_reset();
        check("rst_regWrite", regWrite_o, 0);
        check("rst_busy", busy_o, 0);

        // single ALU result to x5 issued two cycles earlier
        issueValid_i = 1; issueRd_i = 5;
        tick();
        idle();
        tick();
        check("x5_busy_pending", busy_o[5], 1);
        aluValid_i = 1; aluRd_i = 5; aluVal_i = 32'hAA;
        tick();
        idle();
        check("x5_no_bypass", regWrite_o, 0);
        tick();
        check("x5_write", regWrite_o, 1);
        check("x5_rd", rdNum_o, 5);
        check("x5_val", rdVal_o, 32'hAA);
        check("x5_busy_clr", busy_o[5], 0);
        tick();
        check("x5_once", regWrite_o, 0);

        // both sources every cycle: writes alternate starting with the load side
        do_reset();
        for (int i = 0; i < 10; i++) begin
            aluValid_i = 1; aluRd_i = 10; aluVal_i = 32'hA000 + i;
            memValid_i = 1; memRd_i = 11; memVal_i = 32'hB000 + i;
            tick();
            if (i == 1) check("alt_first_mem", rdVal_o, 32'hB000);
            if (i == 2) check("alt_then_alu", rdVal_o, 32'hA000);
        end
        idle();
        repeat (6) tick();

        // three back-to-back ALU results against two queued loads
        do_reset();
        vals[0] = 32'h111; vals[1] = 32'h222; vals[2] = 32'h333;
        k = 0;
        for (int i = 0; i < 14 && k < 3; i++) begin
            memValid_i = i < 2; memRd_i = 12; memVal_i = 32'hC00 + i;
            aluValid_i = 1; aluRd_i = 13; aluVal_i = vals[k];
            if (aluReady_o) k++;
            tick();
        end
        check("fill_all_accepted", k, 3);
        idle();
        repeat (6) tick();

        // result to x0 consumes a grant without writing
        aluValid_i = 1; aluRd_i = 0; aluVal_i = 32'hDEADBEEF;
        tick();
        idle();
        tick();
        check("x0_no_write", regWrite_o, 0);
        check("x0_val_latched", rdVal_o, 32'hDEADBEEF);

        // reissue of x7 on the edge its pending result retires
        issueValid_i = 1; issueRd_i = 7;
        tick();
        idle();
        aluValid_i = 1; aluRd_i = 7; aluVal_i = 32'h77;
        tick();
        idle();
        issueValid_i = 1; issueRd_i = 7;
        tick();
        idle();
        check("x7_write", regWrite_o, 1);
        check("x7_rd", rdNum_o, 7);
        check("x7_still_busy", busy_o[7], 1);

        // reset with queues loaded drops everything
        for (int i = 0; i < 5; i++) begin
            aluValid_i = 1; aluRd_i = 20; aluVal_i = 32'hE00 + i;
            memValid_i = 1; memRd_i = 21; memVal_i = 32'hF00 + i;
            issueValid_i = 1; issueRd_i = 5'(22 + i);
            tick();
        end
        rst_n = 0;
        tick();
        check("mid_rst_regWrite", regWrite_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_aluReady", aluReady_o, 1);
        check("mid_rst_memReady", memReady_o, 1);
        rst_n = 1;
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_write", regWrite_o, 0);
        end

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n = $urandom_range(0, 59) != 0;
            issueValid_i = $urandom_range(0, 2) == 0;
            issueRd_i = 5'($urandom_range(0, 31));
            aluValid_i = $urandom_range(0, 9) < 6;
            aluRd_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            aluVal_i = $urandom;
            memValid_i = $urandom_range(0, 9) < 6;
            memRd_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            memVal_i = $urandom;
            tick();
        end
        rst_n = 1;
        idle();
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
